// File: rtl/tone_sequencer_if.sv
// Control, note-memory and tone-output bundle for tone_sequencer.
// master: controller/memory/divider side; slave: the sequencer itself.
interface tone_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic              stop;
  logic              loop;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rd_period;
  logic [7:0]        rd_dur;
  logic [31:0]       period;
  logic              gate;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop, rd_period, rd_dur,
    input  rd_en, addr, period, gate, busy, done
  );

  modport slave (
    input  start, stop, loop, rd_period, rd_dur,
    output rd_en, addr, period, gate, busy, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Walks a {period, duration} note table and drives a divider period + gate.
// Ports: clk, rst_n (sync, active-low), bus (slave: strobes, memory, tone out).
module tone_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 625000
) (
  input logic            clk,
  input logic            rst_n,
  tone_sequencer_if.slave bus
);

  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PLAY,
    GAP
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    dur_cnt;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      bus.rd_en  <= 1'b0;
      bus.addr   <= '0;
      bus.period <= '0;
      bus.gate   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.rd_en <= 1'b0;
      if (state != IDLE && bus.stop) begin
        state      <= IDLE;
        bus.gate   <= 1'b0;
        bus.period <= '0;
        bus.busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            bus.period <= '0;
            bus.gate   <= 1'b0;
            if (bus.start && !bus.stop) begin
              state     <= FETCH;
              bus.addr  <= '0;
              bus.rd_en <= 1'b1;
              bus.busy  <= 1'b1;
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            if (bus.rd_dur == 8'd0) begin
              // A marker at address 0 would loop forever, so it ends the run.
              if (bus.loop && bus.addr != '0) begin
                state     <= FETCH;
                bus.addr  <= '0;
                bus.rd_en <= 1'b1;
              end else begin
                state      <= IDLE;
                bus.period <= '0;
                bus.busy   <= 1'b0;
                bus.done   <= 1'b1;
              end
            end else begin
              state    <= PLAY;
              beat_cnt <= '0;
              dur_cnt  <= bus.rd_dur;
              if (bus.rd_period >= 32'd2) begin
                bus.period <= bus.rd_period;
                bus.gate   <= 1'b1;
              end else begin
                bus.period <= '0;
                bus.gate   <= 1'b0;
              end
            end
          end
          PLAY: begin
            // dur x BEAT_CYCLES via nested counters instead of a multiply.
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (dur_cnt == 8'd1) begin
                state    <= GAP;
                gap_cnt  <= '0;
                bus.gate <= 1'b0;
              end else begin
                dur_cnt <= dur_cnt - 8'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              if (bus.addr != LAST_ADDR) begin
                state     <= FETCH;
                bus.addr  <= bus.addr + 1'b1;
                bus.rd_en <= 1'b1;
              end else if (bus.loop) begin
                state     <= FETCH;
                bus.addr  <= '0;
                bus.rd_en <= 1'b1;
              end else begin
                state      <= IDLE;
                bus.period <= '0;
                bus.busy   <= 1'b0;
                bus.done   <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
